bicintp_ddr_wr_pack: RTL

- Downstream consumer of the bicubic interpolation calculator's output stream (cmos_bicintp_data / cmos_bicintp_data_vld, RGB565).
- Packs four 16-bit pixels into each 64-bit word and buffers the words in an internal show-ahead FIFO.
- Issues request/acknowledge burst writes to the ddr_rw block with linearly incrementing byte addresses per frame.
- At line end, flushes the partial word and any residual short burst.

---
 rtl/bicintp_ddr_wr_pack.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/bicintp_ddr_wr_pack.sv
// Packs RGB565 pixels four-per-word into a show-ahead FIFO and drains it as req/ack DDR bursts.
// FIFO count follows a packed word by one cycle; wr_req rises one cycle after the burst decision; a full FIFO drops words.

module sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 64
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [W-1:0]             in_dat,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [W-1:0]             out_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          wr, rd;

  assign in_rdy  = (cnt_q != (AW+1)'(DEPTH));
  assign out_vld = (cnt_q != '0);
  assign out_dat = out_vld ? mem[rd_ptr_q] : '0;
  assign count   = cnt_q;
  assign wr      = in_vld && in_rdy;
  assign rd      = out_rdy && out_vld;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr) mem[wr_ptr_q] <= in_dat;
  end
endmodule

module bicintp_ddr_wr_pack #(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 24
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic              line_end,
  input  logic [15:0]       cmos_bicintp_data,
  input  logic              cmos_bicintp_data_vld,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_len,
  output logic [63:0]       wr_data,
  input  logic              wr_data_rd,
  output logic              fifo_ovf,
  output logic              busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t            state_q;
  logic              wr_req_q, flush_q, clr_pend_q, ovf_q;
  logic [6:0]        wr_len_q, beat_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [1:0]        k_q, k_d, k_inc;
  logic [63:0]       word_q, word_d, merged;
  logic              push, pop, fifo_in_rdy, fifo_out_vld;
  logic [CW-1:0]     fifo_cnt;

  // Lane k is filled in place; a flushed word keeps zeros in lanes never written.
  always_comb begin
    merged = word_q;
    if (cmos_bicintp_data_vld) merged[{k_q, 4'b0000} +: 16] = cmos_bicintp_data;
    k_inc  = k_q + {1'b0, cmos_bicintp_data_vld};
    k_d    = k_inc;
    word_d = merged;
    push   = 1'b0;
    if (frame_start) begin
      k_d    = 2'd0;
      word_d = '0;
    end else if ((cmos_bicintp_data_vld && k_q == 2'd3) || (line_end && k_inc != 2'd0)) begin
      push   = 1'b1;
      k_d    = 2'd0;
      word_d = '0;
    end
  end

  assign pop = (state_q == XFER) && wr_data_rd && fifo_out_vld;

  sync_fifo #(.W(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .in_vld  (push),
    .in_rdy  (fifo_in_rdy),
    .in_dat  (merged),
    .out_vld (fifo_out_vld),
    .out_rdy (pop),
    .out_dat (wr_data),
    .count   (fifo_cnt)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      wr_req_q   <= 1'b0;
      wr_len_q   <= '0;
      wr_addr_q  <= '0;
      beat_q     <= '0;
      flush_q    <= 1'b0;
      clr_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      k_q        <= '0;
      word_q     <= '0;
    end else begin
      k_q    <= k_d;
      word_q <= word_d;

      if (frame_start)                ovf_q <= 1'b0;
      else if (push && !fifo_in_rdy)  ovf_q <= 1'b1;

      if (frame_start)                                           flush_q <= 1'b0;
      else if (line_end)                                         flush_q <= 1'b1;
      else if (state_q == IDLE && flush_q && fifo_cnt == '0)     flush_q <= 1'b0;

      if (frame_start && state_q != IDLE) clr_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (frame_start) wr_addr_q <= '0;
          if (fifo_cnt >= BURST_C) begin
            wr_len_q <= 7'(BURST_LEN);
            wr_req_q <= 1'b1;
            state_q  <= REQ;
          end else if (flush_q && fifo_cnt != '0) begin
            wr_len_q <= 7'(fifo_cnt);
            wr_req_q <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (wr_ack) begin
            wr_req_q <= 1'b0;
            beat_q   <= wr_len_q;
            state_q  <= XFER;
          end
        end
        XFER: begin
          if (pop) begin
            beat_q <= beat_q - 7'd1;
            if (beat_q == 7'd1) begin
              state_q <= IDLE;
              // A frame restart seen during the burst takes effect here instead of the advance.
              if (clr_pend_q || frame_start) begin
                wr_addr_q  <= '0;
                clr_pend_q <= 1'b0;
              end else begin
                wr_addr_q <= wr_addr_q + ADDR_W'({wr_len_q, 3'b000});
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_req   = wr_req_q;
  assign wr_len   = wr_len_q;
  assign wr_addr  = wr_addr_q;
  assign fifo_ovf = ovf_q;
  assign busy     = (state_q != IDLE) || fifo_out_vld || flush_q;
endmodule
